axi4_lite_read_arbiter: RTL and testbench

Parametrised AXI4-Lite read master with N_CH host request channels. A round-robin arbiter grants one channel at a time and drives a single AXI4-Lite read address/data channel pair toward a slave. It replaces the fixed 64-bit, single-host read path. It adds configurable data and address widths, multi-host arbitration, alignment checking and response-error reporting back to the host.

---
 rtl/axi4_lite_read_arbiter_if.sv | 24 ++
 rtl/axi4_lite_read_arbiter.sv | 131 +++++++++++++
 tb/tb_axi4_lite_read_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_read_arbiter_if.sv
// AXI4-Lite read address/data channel bundle between the arbiter (master)
// and a downstream slave.
interface axi4_lite_read_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] AR_ADDR;
    logic              AR_VALID;
    logic              AR_READY;
    logic [DATA_W-1:0] R_DATA;
    logic [1:0]        R_RESP;
    logic              R_VALID;
    logic              R_READY;

    modport master (
        output AR_ADDR, AR_VALID, R_READY,
        input  AR_READY, R_DATA, R_RESP, R_VALID
    );

    modport slave (
        input  AR_ADDR, AR_VALID, R_READY,
        output AR_READY, R_DATA, R_RESP, R_VALID
    );
endinterface

// File: rtl/axi4_lite_read_arbiter.sv
// Round-robin arbiter that serialises N_CH host read requests onto a single
// AXI4-Lite read channel pair, with alignment checking and error reporting.
module axi4_lite_read_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int N_CH   = 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_CH-1:0]          R_Request,
    input  logic [N_CH*ADDR_W-1:0]   R_Addr,
    output logic [N_CH-1:0]          R_Finish,
    output logic [N_CH-1:0]          R_Error,
    output logic [DATA_W-1:0]        Data_Out,
    output logic                     Busy,
    axi4_lite_read_arbiter_if.master axi
);
    localparam int ALIGN = $clog2(DATA_W / 8);
    localparam int GW    = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] ch_addr [N_CH];
    logic [GW-1:0]     sel;
    logic [GW-1:0]     cand;
    logic [ADDR_W-1:0] sel_addr;
    logic              misaligned;
    logic              resp_err;
    int                idx;

    always_comb begin
        for (int i = 0; i < N_CH; i++) ch_addr[i] = R_Addr[i*ADDR_W +: ADDR_W];
    end

    // Scan downward so the channel nearest last_grant+1 is assigned last and wins.
    always_comb begin
        sel  = last_grant_q;
        idx  = 0;
        cand = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = int'(last_grant_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            cand = GW'(idx);
            if (R_Request[cand]) sel = cand;
        end
        sel_addr   = ch_addr[sel];
        misaligned = |sel_addr[ALIGN-1:0];
    end

    // SLVERR and DECERR both flag the read as failed.
    assign resp_err = (axi.R_RESP == 2'b10) || (axi.R_RESP == 2'b11);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ar_addr_d    = ar_addr_q;
        data_d       = data_q;
        err_d        = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (|R_Request) begin
                    grant_d   = sel;
                    ar_addr_d = sel_addr;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (axi.AR_READY) state_d = S_DATA;
            end
            S_DATA: begin
                if (axi.R_VALID) begin
                    data_d  = axi.R_DATA;
                    err_d   = resp_err;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_CH - 1);
            ar_addr_q    <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ar_addr_q    <= ar_addr_d;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        R_Finish = '0;
        R_Error  = '0;
        for (int i = 0; i < N_CH; i++) begin
            R_Finish[i] = (state_q == S_RESP) && (grant_q == GW'(i));
            R_Error[i]  = (state_q == S_RESP) && (grant_q == GW'(i)) && err_q;
        end
    end

    assign axi.AR_ADDR  = ar_addr_q;
    assign axi.AR_VALID = (state_q == S_ADDR);
    assign axi.R_READY  = (state_q == S_DATA);
    assign Data_Out     = data_q;
    assign Busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Directed cycle-accurate scenarios followed by randomized traffic checked by
// a transaction-level round-robin model and a completion scoreboard.
module tb_axi4_lite_read_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int NC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NC-1:0]    req = '0;
    logic [AW-1:0]    host_addr [NC];
    logic [NC*AW-1:0] addr_bus;
    logic [NC-1:0]    r_finish, r_error;
    logic [DW-1:0]    data_out;
    logic             busy;

    axi4_lite_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    axi4_lite_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_CH(NC)) dut (
        .CLK(clk), .RST_N(rst_n), .R_Request(req), .R_Addr(addr_bus),
        .R_Finish(r_finish), .R_Error(r_error), .Data_Out(data_out),
        .Busy(busy), .axi(axi)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NC; i++) addr_bus[i*AW +: AW] = host_addr[i];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NC-1:0] onehot(input int c);
        logic [NC-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Reference model and scoreboard state
    typedef struct { int ch; logic [AW-1:0] addr; bit mis; } gnt_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; bit err; } beat_t;
    gnt_t  gq[$];
    beat_t sq[$];
    int    m_state;   // 0 free, 1 waiting for read beat, 2 completion cycle
    int    m_ch;
    int    m_last;
    int    n_fin;
    bit    drain;
    bit    s_ar_done;
    bit    s_r_clear;
    logic [AW-1:0] s_addr;

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        a = $urandom;
        if ($urandom_range(7, 0) == 0) a[2:0] = 3'($urandom_range(7, 1));
        else a[2:0] = 3'b000;
        return a;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        axi.AR_READY = 1'b0;
        axi.R_VALID = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One directed read: cycle 0 is the IDLE cycle that samples the request.
    task automatic run_read(input string tag, input int ch, input logic [AW-1:0] a,
                            input int ad, input int bd, input logic [DW-1:0] d,
                            input logic [1:0] resp, input bit drop);
        bit mis;
        int fin;
        logic arv, rr, bz;
        logic [NC-1:0] f, e;
        mis = (a[2:0] != 3'b000);
        fin = mis ? 1 : 3 + ad + bd;
        @(negedge clk);
        req[ch] = 1'b1;
        host_addr[ch] = a;
        axi.AR_READY = 1'b0;
        axi.R_VALID = 1'b0;
        for (int k = 1; k <= fin + 1; k++) begin
            @(negedge clk);
            arv = !mis && (k <= 1 + ad);
            rr  = !mis && (k >= 2 + ad) && (k <= 2 + ad + bd);
            bz  = (k <= fin);
            f   = (k == fin) ? onehot(ch) : '0;
            e   = (k == fin && (mis || resp[1])) ? onehot(ch) : '0;
            chk($sformatf("%s/cyc%0d", tag, k),
                {axi.AR_VALID, axi.R_READY, busy, r_finish, r_error}, {arv, rr, bz, f, e});
            if (arv) chk($sformatf("%s/ar_addr%0d", tag, k), axi.AR_ADDR, a);
            if (k == fin) begin
                chk($sformatf("%s/data", tag), data_out, mis ? '0 : d);
                req[ch] = 1'b0;
            end
            if (drop && k == 1) req[ch] = 1'b0;
            axi.AR_READY = !mis && (k >= 1 + ad);
            if (!mis && k == 2 + ad + bd) begin
                axi.R_VALID = 1'b1;
                axi.R_DATA  = d;
                axi.R_RESP  = resp;
            end else begin
                axi.R_VALID = 1'b0;
            end
        end
    endtask

    // One cycle of random environment, called just after a falling edge.
    task automatic env_step();
        gnt_t g;
        beat_t s;
        bit r_hs, found;
        int c, chosen;
        logic [NC-1:0] ef;

        ef = (m_state == 2) ? onehot(m_ch) : '0;
        chk("rnd/cycle", {busy, r_finish}, {m_state != 0, ef});
        if (r_finish != '0) begin
            n_fin++;
            if (gq.size() == 0) begin
                chk("rnd/unexpected_finish", r_finish, '0);
            end else begin
                g = gq.pop_front();
                chk("rnd/finish_ch", r_finish, onehot(g.ch));
                if (g.mis) begin
                    chk("rnd/misaligned", {r_error, data_out}, {onehot(g.ch), {DW{1'b0}}});
                end else if (sq.size() == 0) begin
                    chk("rnd/missing_beat", r_finish, '0);
                end else begin
                    s = sq.pop_front();
                    chk("rnd/ar_addr", s.addr, g.addr);
                    chk("rnd/resp", {r_error, data_out}, {s.err ? onehot(g.ch) : '0, s.data});
                end
            end
        end

        for (int i = 0; i < NC; i++) begin
            if (r_finish[i]) begin
                if (!drain && $urandom_range(1, 0) == 1) host_addr[i] = rnd_addr();
                else req[i] = 1'b0;
            end else if (!req[i] && !drain && $urandom_range(3, 0) == 0) begin
                req[i] = 1'b1;
                host_addr[i] = rnd_addr();
            end
        end

        if (s_r_clear) begin
            axi.R_VALID = 1'b0;
            s_r_clear = 1'b0;
        end
        axi.AR_READY = ($urandom_range(2, 0) != 0);
        if (s_ar_done && !axi.R_VALID && $urandom_range(2, 0) == 0) begin
            axi.R_VALID = 1'b1;
            axi.R_DATA  = {$urandom, $urandom};
            axi.R_RESP  = 2'($urandom_range(3, 0));
        end

        if (axi.AR_VALID && axi.AR_READY) begin
            s_ar_done = 1'b1;
            s_addr = axi.AR_ADDR;
        end
        r_hs = axi.R_VALID && axi.R_READY;
        if (r_hs) begin
            s.addr = s_addr;
            s.data = axi.R_DATA;
            s.err  = (axi.R_RESP >= 2'b10);
            sq.push_back(s);
            s_ar_done = 1'b0;
            s_r_clear = 1'b1;
        end

        case (m_state)
            0: if (req != '0) begin
                found = 1'b0;
                chosen = 0;
                for (int k = 1; k <= NC; k++) begin
                    c = (m_last + k) % NC;
                    if (!found && req[c]) begin
                        chosen = c;
                        found = 1'b1;
                    end
                end
                g.ch   = chosen;
                g.addr = host_addr[chosen];
                g.mis  = (host_addr[chosen] % 8) != 0;
                gq.push_back(g);
                m_ch = chosen;
                m_state = g.mis ? 2 : 1;
            end
            1: if (r_hs) m_state = 2;
            default: begin
                m_last = m_ch;
                m_state = 0;
            end
        endcase
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fair_seq[4] = '{0, 1, 0, 1};
        int waited;
        logic [NC-1:0] ef;
        logic [DW-1:0] fd;

        for (int i = 0; i < NC; i++) host_addr[i] = '0;
        axi.AR_READY = 1'b0;
        axi.R_VALID  = 1'b0;
        axi.R_DATA   = '0;
        axi.R_RESP   = 2'b00;

        repeat (2) @(negedge clk);
        chk("reset/ctrl", {axi.AR_VALID, axi.R_READY, busy, r_finish, r_error}, '0);
        chk("reset/data", {axi.AR_ADDR, data_out}, '0);
        rst_n = 1'b1;

        run_read("single", 0, 32'h8000_0000, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 1'b0);
        run_read("backpressure", 0, 32'h8000_0040, 4, 3, 64'h0BAD_F00D_0000_0001, 2'b00, 1'b0);
        run_read("slverr", 1, 32'h0000_1000, 0, 1, 64'hDEAD, 2'b10, 1'b0);
        run_read("decerr", 0, 32'h0000_2008, 1, 0, 64'hDEAD, 2'b11, 1'b0);

        @(negedge clk);
        req[0] = 1'b1;
        host_addr[0] = 32'h0000_0100;
        axi.AR_READY = 1'b1;
        axi.R_VALID = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid/in_data", axi.R_READY, 1'b1);
        rst_n = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid/ctrl", {busy, axi.R_READY, axi.AR_VALID, r_finish}, '0);
        chk("rst_mid/data", data_out, '0);
        rst_n = 1'b1;
        run_read("after_rst_ch1", 1, 32'h4000_0010, 0, 0, 64'hCAFE_F00D_1234_5678, 2'b00, 1'b0);

        run_read("misaligned", 0, 32'h8000_0004, 0, 0, 64'h5555, 2'b00, 1'b0);
        run_read("drop_after_grant", 2, 32'h0000_0300, 2, 2, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1);

        do_reset();
        @(negedge clk);
        req = 3'b011;
        host_addr[0] = 32'h1000_0000;
        host_addr[1] = 32'h2000_0000;
        fd = 64'hA5A5_5A5A_0F0F_F0F0;
        axi.AR_READY = 1'b1;
        axi.R_VALID = 1'b1;
        axi.R_DATA = fd;
        axi.R_RESP = 2'b00;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            ef = (k % 4 == 3) ? onehot(fair_seq[k / 4]) : '0;
            chk($sformatf("fair/cyc%0d", k), {r_finish, r_error}, {ef, {NC{1'b0}}});
            if (k == 15) req = '0;
        end
        chk("fair/data", data_out, fd);
        axi.R_VALID = 1'b0;

        do_reset();
        m_state = 0;
        m_last = NC - 1;
        m_ch = 0;
        n_fin = 0;
        drain = 1'b0;
        s_ar_done = 1'b0;
        s_r_clear = 1'b0;
        s_addr = '0;
        gq.delete();
        sq.delete();
        repeat (3000) begin
            @(negedge clk);
            env_step();
        end
        drain = 1'b1;
        waited = 0;
        while (!(m_state == 0 && req == '0) && waited < 200) begin
            @(negedge clk);
            env_step();
            waited++;
        end
        @(negedge clk);
        env_step();
        chk("rnd/drained", {m_state == 0, req == '0}, 2'b11);
        chk("rnd/grants_left", gq.size(), 0);
        chk("rnd/beats_left", sq.size(), 0);
        chk("rnd/activity", n_fin > 100, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
